load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Parametrised, handshaked load/store unit replacing the fixed word-only,
//  single-cycle data-memory path. Computes base+offset, checks alignment,
//  steers byte lanes, sign/zero-extends loads and talks to a wait-stated
//  data memory via valid/ready. Sits between register file/ALU and data memory.
// PARAMETERS
//  XLEN        32   data/register width; 32 or 64 only
//  ADDR_W      32   memory address width (<= XLEN)
//  TIMEOUT     255  max cycles waiting on memory before error; 0 = never
// PORTS
//  i_clk         in   1         clock, rising edge
//  i_arstn       in   1         asynchronous active-low reset
//  i_reqValid    in   1         core request valid
//  o_reqReady    out  1         LSU accepts request (high only in IDLE)
//  i_reqWrite    in   1         1 = store, 0 = load
//  i_funct3      in   3         RV funct3: size [1:0], unsigned flag [2]
//  i_baseAddr    in   XLEN      rs1 value
//  i_offset      in   XLEN      sign-extended immediate
//  i_storeData   in   XLEN      rs2 value
//  o_rspValid    out  1         one-cycle completion pulse
//  o_rspError    out  1         qualified by o_rspValid: misaligned/illegal/timeout
//  o_loadData    out  XLEN      extended load result, qualified by o_rspValid
//  o_busy        out  1         high whenever state != IDLE
//  o_memValid    out  1         memory request valid
//  i_memReady    in   1         memory accepts request
//  o_memAddr     out  ADDR_W    word-aligned address (low log2(XLEN/8) bits 0)
//  o_memWrite    out  1         1 = write
//  o_memWstrb    out  XLEN/8    byte write strobes
//  o_memWdata    out  XLEN      lane-shifted store data
//  i_memRvalid   in   1         read data valid
//  i_memRdata    in   XLEN      read data word
// BEHAVIOUR
//  - Reset: state IDLE, all outputs 0 except o_reqReady=1; timeout counter 0.
//    Reset mid-transaction aborts silently; no response is issued.
//  - Effective addr = i_baseAddr + i_offset, modulo 2^XLEN, truncated to ADDR_W.
//  - Request registered on i_reqValid & o_reqReady; inputs then ignored.
//  - FSM: IDLE -> REQ (legal, aligned) | RESP w/ error (illegal/misaligned,
//    no memory access). REQ: o_memValid held with stable addr/strb/data until
//    i_memReady; store -> RESP, load -> WAIT. WAIT: until i_memRvalid -> RESP.
//    RESP: o_rspValid=1 for exactly one cycle -> IDLE.
//  - Legal sizes: B, H, W; D (funct3[1:0]=3) only when XLEN=64. funct3[2]=1
//    on a store, or LWU/LD-unsigned at XLEN=32, is illegal.
//  - Misaligned: H with addr[0]!=0, W with addr[1:0]!=0, D with addr[2:0]!=0.
//  - Stores: wstrb = size mask << addr lane; wdata = store data replicated/
//    shifted into that lane. Loads: select lane by addr, sign-extend (funct3[2]=0)
//    or zero-extend to XLEN.
//  - i_memRvalid in REQ or IDLE is ignored; i_memRvalid same cycle as i_memReady
//    in REQ is not permitted by the memory protocol (readback >= 1 cycle later).
//  - Timeout: counter increments each cycle in REQ/WAIT, clears on leaving;
//    reaching TIMEOUT -> RESP with o_rspError=1, o_loadData=0. Late rvalid ignored.
//  - Minimum latency: store 3 cycles accept->rspValid (ready in REQ's 1st
//    cycle); load 4 cycles with 1-cycle readback.
//  - o_loadData=0 on stores and on any error.
// STRUCTURE
//  - lsu_pkg: funct3 size enum (B/H/W/D), state enum (IDLE/REQ/WAIT/RESP),
//    lane-mask function.
//  - Sub-module lsu_align (combinational): lane strobes, store shift, load
//    extract + extend; FSM and timeout stay in load_store_unit.
// TESTING
//  - LW base=0x100 off=4, mem[0x104]=0xDEADBEEF, ready immediate, rvalid +1
//    -> addr 0x104, rspValid once, loadData 0xDEADBEEF, error 0.
//  - LB base=0x103 off=0, word 0x80FF_0000 -> loadData 0xFFFFFF80;
//    LBU same -> 0x00000080; LHU at 0x102 -> 0x000080FF.
//  - SH data 0x1234ABCD at 0x106, ready after 3 stall cycles -> memValid
//    held 4 cycles, addr 0x104, wstrb 4'b1100, wdata[31:16]=0xABCD.
//  - LW at 0x102 -> no memValid, rspValid next cycle after accept, error 1.
//  - LW, rvalid never arrives, TIMEOUT=8 -> error response after 8 WAIT
//    cycles; subsequent request accepted normally.
//  - Deassert i_arstn during WAIT -> outputs reset asynchronously, no rspValid.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access size, FSM states, lane masks.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_e;

  // Byte-enable pattern for an access of the given size, anchored at lane 0.
  function automatic logic [7:0] laneMask(input size_e size);
    logic [7:0] m;
    case (size)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-side request/response and memory-side bus bundles for the LSU.
interface lsu_req_if #(parameter int XLEN = 32);
  logic            reqValid;
  logic            reqReady;
  logic            reqWrite;
  logic [2:0]      funct3;
  logic [XLEN-1:0] baseAddr;
  logic [XLEN-1:0] offset;
  logic [XLEN-1:0] storeData;
  logic            rspValid;
  logic            rspError;
  logic [XLEN-1:0] loadData;
  logic            busy;

  modport master (
    output reqValid, reqWrite, funct3, baseAddr, offset, storeData,
    input  reqReady, rspValid, rspError, loadData, busy
  );
  modport slave (
    input  reqValid, reqWrite, funct3, baseAddr, offset, storeData,
    output reqReady, rspValid, rspError, loadData, busy
  );
endinterface

interface lsu_mem_if #(parameter int XLEN = 32, parameter int ADDR_W = 32);
  logic              memValid;
  logic              memReady;
  logic [ADDR_W-1:0] memAddr;
  logic              memWrite;
  logic [XLEN/8-1:0] memWstrb;
  logic [XLEN-1:0]   memWdata;
  logic              memRvalid;
  logic [XLEN-1:0]   memRdata;

  modport master (
    output memValid, memAddr, memWrite, memWstrb, memWdata,
    input  memReady, memRvalid, memRdata
  );
  modport slave (
    input  memValid, memAddr, memWrite, memWstrb, memWdata,
    output memReady, memRvalid, memRdata
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store strobes/shift and load extract with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  size_e                       size,
  input  logic                        isUnsigned,
  input  logic [$clog2(XLEN/8)-1:0]   lane,
  input  logic [XLEN-1:0]             storeData,
  input  logic [XLEN-1:0]             rdata,
  output logic [XLEN/8-1:0]           wstrb,
  output logic [XLEN-1:0]             wdata,
  output logic [XLEN-1:0]             loadData
);
  localparam int NB   = XLEN / 8;
  localparam int IDXW = $clog2(XLEN);

  logic [7:0]      mask;
  logic [IDXW-1:0] shamt;
  logic [XLEN-1:0] shifted;
  logic [IDXW-1:0] topBit;
  logic            extBit;

  assign mask    = laneMask(size);
  assign shamt   = {lane, 3'b000};
  assign wstrb   = mask[NB-1:0] << lane;
  assign wdata   = storeData << shamt;
  assign shifted = rdata >> shamt;

  // Pick the addressed lane down to bit 0, then fill everything above its MSB.
  always_comb begin
    case (size)
      SZ_B:    topBit = IDXW'(7);
      SZ_H:    topBit = IDXW'(15);
      SZ_W:    topBit = IDXW'(31);
      default: topBit = IDXW'(XLEN - 1);
    endcase
    extBit   = ~isUnsigned & shifted[topBit];
    loadData = shifted;
    for (int i = 0; i < XLEN; i++) begin
      if (i > int'(topBit)) loadData[i] = extBit;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Handshaked load/store unit: address generation, legality/alignment checks,
// memory request sequencing with timeout, and single-cycle response pulse.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic       i_clk,
  input logic       i_arstn,
  lsu_req_if.slave  core,
  lsu_mem_if.master mem
);
  localparam int OFFW  = $clog2(XLEN / 8);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e            state, stateNext;
  logic              wrReg, unsReg, errReg;
  size_e             sizeReg;
  logic [ADDR_W-1:0] addrReg;
  logic [XLEN-1:0]   dataReg, loadReg;
  logic [CNT_W-1:0]  cnt;

  logic [XLEN-1:0]   effSum;
  logic [ADDR_W-1:0] effAddr;
  size_e             reqSize;
  logic              reqBad, accept, timeoutHit, timeoutEvt, inReq;
  logic [XLEN/8-1:0] alignWstrb;
  logic [XLEN-1:0]   alignWdata, alignLoad;

  assign effSum     = core.baseAddr + core.offset;
  assign effAddr    = effSum[ADDR_W-1:0];
  assign reqSize    = size_e'(core.funct3[1:0]);
  assign accept     = core.reqValid & (state == IDLE);
  assign timeoutHit = (TIMEOUT != 0) && (cnt == CNT_LAST);
  assign inReq      = (state == REQ);

  // Illegal encodings and misaligned addresses complete with an error and never touch memory.
  always_comb begin
    reqBad = 1'b0;
    if (reqSize == SZ_D && XLEN == 32) reqBad = 1'b1;
    if (core.funct3[2] && core.reqWrite) reqBad = 1'b1;
    if (core.funct3[2] && XLEN == 32 && (reqSize == SZ_W || reqSize == SZ_D)) reqBad = 1'b1;
    case (reqSize)
      SZ_H:    if (effAddr[0] != 1'b0) reqBad = 1'b1;
      SZ_W:    if (effAddr[1:0] != 2'b00) reqBad = 1'b1;
      SZ_D:    if (effAddr[2:0] != 3'b000) reqBad = 1'b1;
      default: ;
    endcase
  end

  lsu_align #(.XLEN(XLEN)) u_align (
    .size      (sizeReg),
    .isUnsigned(unsReg),
    .lane      (addrReg[OFFW-1:0]),
    .storeData (dataReg),
    .rdata     (mem.memRdata),
    .wstrb     (alignWstrb),
    .wdata     (alignWdata),
    .loadData  (alignLoad)
  );

  // Next-state logic; data handshakes take priority over a timeout in the same cycle.
  always_comb begin
    stateNext  = state;
    timeoutEvt = 1'b0;
    case (state)
      IDLE: if (accept) stateNext = reqBad ? RESP : REQ;
      REQ: begin
        if (mem.memReady) stateNext = wrReg ? RESP : WAIT;
        else if (timeoutHit) begin
          stateNext  = RESP;
          timeoutEvt = 1'b1;
        end
      end
      WAIT: begin
        if (mem.memRvalid) stateNext = RESP;
        else if (timeoutHit) begin
          stateNext  = RESP;
          timeoutEvt = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // State, per-state cycle counter and captured request/response fields.
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      state   <= IDLE;
      cnt     <= '0;
      wrReg   <= 1'b0;
      unsReg  <= 1'b0;
      errReg  <= 1'b0;
      sizeReg <= SZ_B;
      addrReg <= '0;
      dataReg <= '0;
      loadReg <= '0;
    end else begin
      state <= stateNext;
      if (stateNext != state || !(state == REQ || state == WAIT)) cnt <= '0;
      else cnt <= cnt + 1'b1;
      if (accept) begin
        wrReg   <= core.reqWrite;
        unsReg  <= core.funct3[2];
        sizeReg <= reqSize;
        addrReg <= effAddr;
        dataReg <= core.storeData;
        errReg  <= reqBad;
        loadReg <= '0;
      end
      if (state == WAIT && mem.memRvalid) loadReg <= alignLoad;
      if (timeoutEvt) begin
        errReg  <= 1'b1;
        loadReg <= '0;
      end
    end
  end

  assign core.reqReady = (state == IDLE);
  assign core.busy     = (state != IDLE);
  assign core.rspValid = (state == RESP);
  assign core.rspError = (state == RESP) & errReg;
  assign core.loadData = (state == RESP && !errReg && !wrReg) ? loadReg : '0;

  assign mem.memValid = inReq;
  assign mem.memAddr  = inReq ? {addrReg[ADDR_W-1:OFFW], OFFW'(0)} : '0;
  assign mem.memWrite = inReq & wrReg;
  assign mem.memWstrb = (inReq & wrReg) ? alignWstrb : '0;
  assign mem.memWdata = (inReq & wrReg) ? alignWdata : '0;

endmodule
